// File: rtl/data_memory_responder.sv
// Word-organised data RAM behind a valid/ready load/store request channel, with
// WAIT_CYCLES programmable wait states. Define MEMORY_RESPONDER_CHECK_EN to flag misaligned/out-of-range addresses.
module data_memory_responder #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        requestValid,
  output logic        requestReady,
  input  logic        requestWrite,
  input  logic [31:0] requestAddress,
  input  logic [31:0] requestWriteData,
  input  logic [3:0]  requestByteEnable,
  output logic        responseValid,
  input  logic        responseReady,
  output logic [31:0] responseReadData,
  output logic        responseError,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_ACCESS  = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  logic [1:0]               state;
  logic [7:0]               wait_counter;
  logic                     lat_write;
  logic [ADDRESS_WIDTH-1:0] lat_index;
  logic [31:0]              lat_data;
  logic [3:0]               lat_be;
  logic                     lat_error;
  logic [31:0]              read_data;
  logic                     resp_error;
  logic                     req_flag;
  logic                     ram_we;

  logic [31:0] ram [DEPTH];

`ifdef MEMORY_RESPONDER_CHECK_EN
  assign req_flag = (requestAddress[1:0] != 2'b00) ||
                    (requestAddress[31:ADDRESS_WIDTH+2] != '0);
`else
  // Unchecked build: untranslated address bits simply alias.
  logic unused_addr;
  assign unused_addr = ^{requestAddress[31:ADDRESS_WIDTH+2], requestAddress[1:0]};
  assign req_flag    = 1'b0;
`endif

  assign requestReady     = (state == S_IDLE);
  assign busy             = (state != S_IDLE);
  assign responseValid    = (state == S_RESPOND);
  assign responseReadData = read_data;
  assign responseError    = resp_error;

  assign ram_we = (state == S_ACCESS) && lat_write && !lat_error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wait_counter <= '0;
      lat_write    <= 1'b0;
      lat_index    <= '0;
      lat_data     <= '0;
      lat_be       <= '0;
      lat_error    <= 1'b0;
      read_data    <= '0;
      resp_error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (requestValid) begin
            lat_write    <= requestWrite;
            lat_index    <= requestAddress[ADDRESS_WIDTH+1:2];
            lat_data     <= requestWriteData;
            lat_be       <= requestByteEnable;
            lat_error    <= req_flag;
            wait_counter <= WAIT_INIT;
            state        <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_counter <= wait_counter - 8'd1;
          if (wait_counter <= 8'd1) begin
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Flagged requests and stores both answer with zero data.
          if (lat_error) begin
            read_data  <= '0;
            resp_error <= 1'b1;
          end else if (lat_write) begin
            read_data  <= '0;
            resp_error <= 1'b0;
          end else begin
            read_data  <= ram[lat_index];
            resp_error <= 1'b0;
          end
          state <= S_RESPOND;
        end
        S_RESPOND: begin
          if (responseReady) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM array is intentionally not reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lat_be[b]) begin
          ram[lat_index][8*b +: 8] <= lat_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized and directed self-checking bench for data_memory_responder against a word-array model.
module tb_data_memory_responder;

  localparam int AW = 10;
  localparam int W  = 2;

  logic        clock;
  logic        reset;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_error, busy;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_resp_valid, z_resp_ready, z_resp_error, z_busy;
  logic [31:0] z_resp_rdata;

  int checks = 0;
  int errors = 0;

  // Reference RAM contents, keyed by word index (only written words are compared).
  logic [31:0] model [int];

  data_memory_responder #(.ADDRESS_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset),
    .requestValid(req_valid), .requestReady(req_ready), .requestWrite(req_write),
    .requestAddress(req_addr), .requestWriteData(req_wdata), .requestByteEnable(req_be),
    .responseValid(resp_valid), .responseReady(resp_ready),
    .responseReadData(resp_rdata), .responseError(resp_error), .busy(busy)
  );

  data_memory_responder #(.ADDRESS_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .requestValid(z_req_valid), .requestReady(z_req_ready), .requestWrite(z_req_write),
    .requestAddress(z_req_addr), .requestWriteData(z_req_wdata), .requestByteEnable(z_req_be),
    .responseValid(z_resp_valid), .responseReady(z_resp_ready),
    .responseReadData(z_resp_rdata), .responseError(z_resp_error), .busy(z_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % (1 << AW));
  endfunction

  // Runs one full transaction on the W-cycle instance; lat counts edges from the accepting edge (inclusive) to responseValid.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    bit ok;
    ok = 0; lat = 0; rd = '0; er = 1'b0;
    req_write = wr; req_addr = addr; req_wdata = data; req_be = be;
    req_valid = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      logic was;
      was = req_ready;
      @(posedge clock); #1;
      if (was) ok = 1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h", addr);
      return;
    end
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL response_timeout addr=%h", addr);
      return;
    end
    rd = resp_rdata;
    er = resp_error;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0; z_resp_ready = 0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", resp_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (z_req_ready !== 1'b1 || z_resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_w0 got ready=%b valid=%b exp 1/0", z_req_ready, z_resp_valid);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    model[word_of(32'h10)] = 32'hDEADBEEF;
    checks++; if (lat != W + 2) begin errors++; $display("FAIL store_latency got=%0d exp=%0d", lat, W + 2); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL store_resp got=%h/%b exp=0/0", rd, er); end
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++; if (lat != W + 2) begin errors++; $display("FAIL load_latency got=%0d exp=%0d", lat, W + 2); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got=%h exp=DEADBEEF", rd); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    model[word_of(32'h20)] = 32'h11BB33DD;
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL byte_enable got=%h exp=11BB33DD", rd); end
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    checks++; if (lat != W + 2 || er !== 1'b0) begin errors++; $display("FAIL be0_resp got lat=%0d err=%b exp %0d/0", lat, er, W + 2); end
    xact(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be0_nowrite got=%h exp=11BB33DD", rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat; bit ok; int n;
    req_write = 1'b0; req_addr = 32'h10; req_wdata = '0; req_be = 4'h0;
    req_valid = 1'b1; resp_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      logic was;
      was = req_ready;
      @(posedge clock); #1;
      if (was) ok = 1;
    end
    // Second request held pending while the first response is stalled.
    req_addr = 32'h20;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clock); #1; n++; end
    checks++; if (!ok || !resp_valid) begin errors++; $display("FAIL bp_reach_respond got ok=%0d valid=%b exp 1/1", ok, resp_valid); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== model[word_of(32'h10)] || req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got valid=%b data=%h ready=%b busy=%b exp 1/%h/0/1",
                 c, resp_valid, resp_rdata, req_ready, busy, model[word_of(32'h10)]);
      end
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b exp 0/1", resp_valid, req_ready);
    end
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== model[word_of(32'h20)] || lat != W + 2) begin
      errors++; $display("FAIL bp_pending got data=%h lat=%0d exp %h/%0d", rd, lat, model[word_of(32'h20)], W + 2);
    end
  endtask

  task automatic test_check;
    logic [31:0] rd; logic er; int lat;
`ifdef MEMORY_RESPONDER_CHECK_EN
    xact(1'b0, 32'h00000002, 32'h0, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != W + 2) begin
      errors++; $display("FAIL chk_misalign got err=%b data=%h lat=%0d exp 1/0/%0d", er, rd, lat, W + 2);
    end
    xact(1'b0, 32'h00001000, 32'h0, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL chk_range got err=%b data=%h exp 1/0", er, rd); end
    xact(1'b1, 32'h00001010, 32'hCAFEF00D, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL chk_store_flag got err=%b exp 1", er); end
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== model[word_of(32'h10)] || er !== 1'b0) begin
      errors++; $display("FAIL chk_ram_unchanged got=%h/%b exp %h/0", rd, er, model[word_of(32'h10)]);
    end
`else
    xact(1'b1, 32'h00001010, 32'hCAFEF00D, 4'hF, rd, er, lat);
    model[word_of(32'h1010)] = 32'hCAFEF00D;
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL alias_store_err got=%b exp 0", er); end
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_load got=%h exp=CAFEF00D", rd); end
`endif
  endtask

  task automatic test_reset_during_wait;
    logic [31:0] rd; logic er; int lat; bit ok;
    xact(1'b1, 32'h30, 32'h55AA55AA, 4'hF, rd, er, lat);
    model[word_of(32'h30)] = 32'h55AA55AA;
    xact(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL rst_preload got=%h exp=55AA55AA", rd); end
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_be = 4'hF;
    req_valid = 1'b1; resp_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      logic was;
      was = req_ready;
      @(posedge clock); #1;
      if (was) ok = 1;
    end
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (!ok || req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_wait got ready=%b valid=%b data=%h err=%b busy=%b exp 1/0/0/0/0",
               req_ready, resp_valid, resp_rdata, resp_error, busy);
    end
    #1 reset = 1'b1;
    @(posedge clock); #1;
    xact(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL rst_no_commit got=%h exp=55AA55AA", rd); end
  endtask

  task automatic test_random;
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      xact(1'b1, 32'h100 + 32'(i * 4), d, 4'hF, rd, er, lat);
      model[64 + i] = d;
    end
    for (int k = 0; k < 60; k++) begin
      int idx; logic [31:0] d; logic [3:0] be; logic [31:0] a;
      idx = 64 + int'($urandom_range(0, 15));
      a   = 32'(idx * 4);
      d   = $urandom;
      be  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        xact(1'b1, a, d, be, rd, er, lat);
        model[idx] = (model[idx] & ~lane_mask(be)) | (d & lane_mask(be));
      end else begin
        xact(1'b0, a, d, be, rd, er, lat);
        checks++;
        if (rd !== model[idx] || er !== 1'b0 || lat != W + 2) begin
          errors++;
          $display("FAIL rand_load idx=%0d got=%h/%b lat=%0d exp=%h/0 lat=%0d", idx, rd, er, lat, model[idx], W + 2);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit ok; int acc_cyc [$]; logic [31:0] exp_q [$]; int cyc; int nacc;
    logic [31:0] words [2];
    words[0] = 32'hA5A5_0001;
    words[1] = 32'h5A5A_0002;
    // Seed two words, then a single-request latency check.
    for (int i = 0; i < 2; i++) begin
      z_req_write = 1'b1; z_req_addr = 32'h40 + 32'(i * 4); z_req_wdata = words[i]; z_req_be = 4'hF;
      z_req_valid = 1'b1; z_resp_ready = 1'b1;
      @(posedge clock); #1;
      z_req_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin @(posedge clock); #1; end
    end
    z_req_write = 1'b0; z_req_addr = 32'h40; z_req_valid = 1'b1;
    ok = (z_req_ready === 1'b1);
    @(posedge clock); #1;
    z_req_valid = 1'b0;
    lat = 1;
    while (!z_resp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++; if (!ok || lat != 2 || z_resp_rdata !== words[0]) begin
      errors++; $display("FAIL w0_latency got lat=%0d data=%h exp 2/%h", lat, z_resp_rdata, words[0]);
    end
    @(posedge clock); #1;
    cyc = 0; nacc = 0;
    z_req_valid = 1'b1;
    z_req_addr  = 32'h40;
    while (nacc < 4 && cyc < 40) begin
      logic was;
      was = z_req_ready;
      @(posedge clock); #1;
      cyc++;
      if (z_resp_valid) begin
        checks++;
        if (exp_q.size() == 0 || z_resp_rdata !== exp_q[0]) begin
          errors++; $display("FAIL b2b_data got=%h exp=%h", z_resp_rdata, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (was) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(words[nacc % 2]);
        nacc++;
        z_req_addr = 32'h40 + 32'((nacc % 2) * 4);
      end
    end
    z_req_valid = 1'b0;
    checks++; if (nacc != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", nacc); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
        errors++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=3", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    for (int j = 0; j < 3; j++) begin @(posedge clock); #1; end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_enable;
    test_backpressure;
    test_check;
    test_reset_during_wait;
    test_random;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Single-port data-memory responder serving the CPU's MEM-stage load/store requests over a valid/ready request channel and a valid/ready response channel. Holds a word-organised RAM and inserts a programmable number of wait states before each access, so the pipeline's memory-stall logic can be exercised against realistic latency. Sits between the CPU core and the data memory array, as the target end of the core's data-memory interface.

## Interface
- ADDRESS_WIDTH, 10: word-index bits; RAM depth = 2^ADDRESS_WIDTH 32-bit words.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and array access (0..255).

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- requestValid  in  1  request present.
- requestReady  out  1  responder can accept; equals (state == IDLE).
- requestWrite  in  1  1 = store, 0 = load.
- requestAddress  in  32  byte address; word index = requestAddress[ADDRESS_WIDTH+1:2].
- requestWriteData  in  32  store data.
- requestByteEnable  in  4  store byte lanes; bit n enables bits [8n+7:8n].
- responseValid  out  1  response present.
- responseReady  in  1  requester consumes response.
- responseReadData  out  32  load data, registered.
- responseError  out  1  request rejected (see Configuration).
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, WAIT, ACCESS, RESPOND.
- IDLE: requestReady = 1. On requestValid at an edge: latch write, address, data, byte enables; load waitCounter = WAIT_CYCLES; go WAIT, or ACCESS if WAIT_CYCLES = 0.
- WAIT: waitCounter decrements each edge; at the edge where it reaches 0 (i.e. waitCounter == 1), go ACCESS.
- ACCESS: one cycle. Store: write enabled lanes only; lanes with enable 0 unchanged; byte enable 0000 writes nothing but still responds. Load: read full word into responseReadData (byte enables ignored). Go RESPOND.
- RESPOND: responseValid = 1; responseReadData/responseError held stable. On responseReady at an edge, go IDLE and clear responseValid. Store responses return responseReadData = 0.
- No request is accepted outside IDLE; requestValid in other states is ignored (requester must hold it).
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, requestReady 1, responseValid 0, responseReadData 0, responseError 0, busy 0, waitCounter 0.
- responseValid rises exactly WAIT_CYCLES + 2 edges after the accepting edge (4 with default).
- responseReady already high on the first RESPOND cycle: one-cycle response; requestReady high on the following cycle. Minimum request spacing WAIT_CYCLES + 3 cycles.
- Store commits to the RAM at the edge leaving ACCESS; a subsequent load sees it.
- Reset asserted in any state: outputs take reset values immediately; pending request dropped; a store not yet past its ACCESS edge does not commit. Reset wins over a coincident ACCESS edge.
- Address bits above ADDRESS_WIDTH+1 and bits [1:0] ignored when the check is compiled out (aliasing).

## Configuration
- MEMORY_RESPONDER_CHECK_EN defined: at acceptance, a request with requestAddress[1:0] != 0 or any of requestAddress[31:ADDRESS_WIDTH+2] set is flagged. A flagged request follows the same states and latency, performs no RAM access, and responds with responseError = 1 and responseReadData = 0.
- Undefined: no checking; responseError tied 0; addresses alias as above.

## Test plan
- Store 0xDEADBEEF to 0x10 with byte enable 1111, then load 0x10 -> responseReadData 0xDEADBEEF; responseValid exactly 4 edges after each accepting edge.
- Store 0x11223344 to 0x20, store 0xAABBCCDD to 0x20 with byte enable 0101, load 0x20 -> 0x11BB33DD.
- Load with responseReady held low 5 cycles -> responseValid and data stable throughout, requestReady 0, a concurrent requestValid is not accepted until after consumption.
- With MEMORY_RESPONDER_CHECK_EN: load 0x00000002 and load 0x00001000 -> responseError 1, data 0, RAM unchanged. Without it: store 0xCAFEF00D to 0x1010, load 0x10 -> 0xCAFEF00D.
- Store 0x55AA55AA to 0x30; then store 0x12345678 to 0x30 and pulse reset low during WAIT -> all outputs at reset values; load 0x30 -> 0x55AA55AA.
- WAIT_CYCLES = 0: load -> responseValid 2 edges after acceptance; back-to-back requests accepted every 3 cycles with responseReady tied high.
